cory_pack16: RTL and testbench
==============================

// Module: cory_pack16
// PURPOSE
//  16-to-1 stream joiner. The inverse of the 16-way unpack: sixteen independent
//  valid/ready lanes are gathered into one wide valid/ready beat.
//  - Each lane has a one-entry holding register.
//  - A beat is emitted once every lane holds data.
//  - Sits where per-field producers reassemble a record for a single wide consumer.
// PARAMETERS
//  N      8                 default width of every lane
//  A0..AF N                 width of lane 0..15 (hex suffix: A0..A9, AA..AF)
//  Z      sum(A0..AF)       packed output width (derived; do not override)
// PORTS
//  clk      in   1    clock; all state on posedge
//  reset_n  in   1    asynchronous active-low reset
//  i_ak_v   in   1    lane k valid (k = 0..9, a..f)
//  i_ak_d   in   Ak   lane k data
//  o_ak_r   out  1    lane k ready
//  o_z_v    out  1    packed beat valid
//  o_z_d    out  Z    packed data; lane 0 in LSBs, {AF,...,A1,A0} order
//  i_z_r    in   1    packed beat ready
// BEHAVIOUR
//  - Reset (async, while reset_n == 0):
//    - all full_k = 0, lane regs = 0, o_z_v = 0, o_z_d = 0.
//    - all o_ak_r = 1 one gate after reset_n deasserts.
//  - Handshakes:
//    - Lane capture: i_ak_v & o_ak_r.
//    - Output fire = o_z_v & i_z_r.
//  - Base mode:
//    - o_ak_r = ~full_k | fire. Combinational path i_z_r -> o_ak_r is allowed.
//    - o_z_v = &full_k. All outputs come from registers; no comb path from i_* to o_z_*.
//    - On fire, every full_k clears, except lanes capturing in the same cycle.
//      Those stay full with the new data.
//  - Latency: 1 cycle from the capture of the last-arriving lane to o_z_v.
//  - Throughput: 1 beat/cycle when all lanes are continuously valid and i_z_r = 1.
//  - Backpressure: while o_z_v & ~i_z_r, o_z_d is stable, and every full lane
//    holds its register with o_ak_r = 0.
//  - Per-lane state: EMPTY -> FULL on capture; FULL -> EMPTY on fire;
//    FULL -> FULL on fire with same-cycle capture.
//  - Early lanes (arrive before others): they capture and then stall. No ordering
//    is required among lanes.
//  - Data rules: no arithmetic and no width change per lane; o_z_d is the plain
//    concatenation of the lane registers.
//  - Reset mid-operation: partially collected lanes are discarded; no beat is emitted.
// CONFIGURATION
//  CORY_PACK16_BYPASS_EN defined:
//  - An empty lane with i_ak_v = 1 contributes combinationally:
//    - o_z_v = &(full_k | i_ak_v)
//    - lane k slice = full_k ? reg_k : i_ak_d
//  - o_ak_r = ~full_k; no comb path i_z_r -> o_ak_r.
//  - Empty lane handshake in a fire cycle: data is consumed directly and not stored
//    (full_k stays 0).
//  - Empty lane handshake without fire: data is captured.
//  - Full lanes clear on fire but cannot recapture in that cycle.
//  - Latency 0 when all lanes arrive together.
//  Undefined: base mode above.
// STRUCTURE
//  Shared cory include:
//  - `ifndef CORY_PACK16 guard.
//  - Lane-offset localparams (OFS_k = A0 + ... + A(k-1)), reused by the unpack
//    and pack families.
//  Sub-module cory_pack_lane #(W):
//  - Ports: clk, reset_n, i_v, i_d, o_r, i_fire, o_full, o_d.
//  - Owns full/reg and both config variants.
//  Top level:
//  - Instantiates cory_pack_lane 16 times.
//  - AND-reduces the full flags, concatenates the slices, and drives fire.
//  SIM-only CORY_MON block for transaction logging.
// TESTING (N = 8, base mode unless noted)
//  - Reset: reset_n = 0 with all i_ak_v = 1.
//    -> o_z_v = 0, o_z_d = 0. After release, all o_ak_r = 1; o_z_v = 1 on the
//       following cycle.
//  - Staggered: lane k drives 8'h10+k in cycle k, i_z_r = 1.
//    -> o_z_v rises at cycle 16, o_z_d = 128'h1F1E...1110. Early lanes show o_ak_r = 0
//       until fire.
//  - Backpressure: full beat, i_z_r = 0 for 5 cycles.
//    -> o_z_v and o_z_d stable, all o_ak_r = 0. On i_z_r = 1: one fire, no duplicate.
//  - Streaming: all lanes valid with an incrementing pattern, i_z_r = 1.
//    -> 1 beat/cycle; beat n carries lane value n in every slice.
//  - Reset mid-collect: lanes 0..7 captured, then reset_n pulses low.
//    -> no beat emitted; the next full set is emitted alone.
//  - BYPASS_EN: all lanes valid in one cycle with i_z_r = 1.
//    -> o_z_v in the same cycle, full_k stays 0. Repeat with i_z_r = 0.
//    -> lanes captured; beat is emitted the next cycle.

Source files
------------

// File: rtl/cory_pack16_pkg.sv
// cory_pack16_pkg: lane count and lane-offset helper shared by the cory pack/unpack families
`ifndef CORY_PACK16
`define CORY_PACK16
package cory_pack16_pkg;
  localparam int LANES = 16;
  typedef logic [LANES-1:0][31:0] widths_t;
  function automatic int lane_ofs(input widths_t w, input int k);
    int s = 0;
    for (int i = 0; i < k; i++) s += int'(w[i]);
    return s;
  endfunction
endpackage
`endif

// File: rtl/cory_pack16_lane.sv
// cory_pack_lane: one-entry holding register for a single cory_pack16 lane
// CORY_PACK16_BYPASS_EN lets an empty lane feed the beat combinationally
module cory_pack_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_v,
  input  logic [W-1:0] i_d,
  output logic         o_r,
  input  logic         i_fire,
  output logic         o_full,
  output logic [W-1:0] o_d
);
  logic         full;
  logic         cap;
  logic [W-1:0] d_q;
`ifdef CORY_PACK16_BYPASS_EN
  // an empty lane's data in a fire cycle leaves directly, so it is never stored
  assign o_r = ~full;
  assign cap = i_v & ~full & ~i_fire;
  assign o_d = full ? d_q : i_d;
`else
  assign o_r = ~full | i_fire;
  assign cap = i_v & o_r;
  assign o_d = d_q;
`endif
  assign o_full = full;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
      d_q  <= '0;
    end else begin
      full <= cap | (full & ~i_fire);
      if (cap) d_q <= i_d;
    end
  end
endmodule

// File: rtl/cory_pack16.sv
// cory_pack16: joins sixteen valid/ready lanes into one wide beat (lane 0 in LSBs)
// CORY_PACK16_BYPASS_EN: empty valid lanes contribute combinationally; CORY_MON: sim beat log
module cory_pack16
  import cory_pack16_pkg::*;
#(
  parameter int N  = 8,
  parameter int A0 = N,
  parameter int A1 = N,
  parameter int A2 = N,
  parameter int A3 = N,
  parameter int A4 = N,
  parameter int A5 = N,
  parameter int A6 = N,
  parameter int A7 = N,
  parameter int A8 = N,
  parameter int A9 = N,
  parameter int AA = N,
  parameter int AB = N,
  parameter int AC = N,
  parameter int AD = N,
  parameter int AE = N,
  parameter int AF = N,
  parameter int Z  = A0 + A1 + A2 + A3 + A4 + A5 + A6 + A7 + A8 + A9 + AA + AB + AC + AD + AE + AF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_a0_v,
  input  logic [A0-1:0] i_a0_d,
  output logic          o_a0_r,
  input  logic          i_a1_v,
  input  logic [A1-1:0] i_a1_d,
  output logic          o_a1_r,
  input  logic          i_a2_v,
  input  logic [A2-1:0] i_a2_d,
  output logic          o_a2_r,
  input  logic          i_a3_v,
  input  logic [A3-1:0] i_a3_d,
  output logic          o_a3_r,
  input  logic          i_a4_v,
  input  logic [A4-1:0] i_a4_d,
  output logic          o_a4_r,
  input  logic          i_a5_v,
  input  logic [A5-1:0] i_a5_d,
  output logic          o_a5_r,
  input  logic          i_a6_v,
  input  logic [A6-1:0] i_a6_d,
  output logic          o_a6_r,
  input  logic          i_a7_v,
  input  logic [A7-1:0] i_a7_d,
  output logic          o_a7_r,
  input  logic          i_a8_v,
  input  logic [A8-1:0] i_a8_d,
  output logic          o_a8_r,
  input  logic          i_a9_v,
  input  logic [A9-1:0] i_a9_d,
  output logic          o_a9_r,
  input  logic          i_aa_v,
  input  logic [AA-1:0] i_aa_d,
  output logic          o_aa_r,
  input  logic          i_ab_v,
  input  logic [AB-1:0] i_ab_d,
  output logic          o_ab_r,
  input  logic          i_ac_v,
  input  logic [AC-1:0] i_ac_d,
  output logic          o_ac_r,
  input  logic          i_ad_v,
  input  logic [AD-1:0] i_ad_d,
  output logic          o_ad_r,
  input  logic          i_ae_v,
  input  logic [AE-1:0] i_ae_d,
  output logic          o_ae_r,
  input  logic          i_af_v,
  input  logic [AF-1:0] i_af_d,
  output logic          o_af_r,
  output logic          o_z_v,
  output logic [Z-1:0]  o_z_d,
  input  logic          i_z_r
);
  localparam widths_t W = {32'(AF), 32'(AE), 32'(AD), 32'(AC), 32'(AB), 32'(AA), 32'(A9), 32'(A8),
                           32'(A7), 32'(A6), 32'(A5), 32'(A4), 32'(A3), 32'(A2), 32'(A1), 32'(A0)};
  logic [LANES-1:0] in_v;
  logic [LANES-1:0] full;
  logic [LANES-1:0] rdy;
  logic [Z-1:0]     in_d;
  logic [Z-1:0]     lane_d;
  logic             fire;
  assign in_v = {i_af_v, i_ae_v, i_ad_v, i_ac_v, i_ab_v, i_aa_v, i_a9_v, i_a8_v,
                 i_a7_v, i_a6_v, i_a5_v, i_a4_v, i_a3_v, i_a2_v, i_a1_v, i_a0_v};
  assign in_d = {i_af_d, i_ae_d, i_ad_d, i_ac_d, i_ab_d, i_aa_d, i_a9_d, i_a8_d,
                 i_a7_d, i_a6_d, i_a5_d, i_a4_d, i_a3_d, i_a2_d, i_a1_d, i_a0_d};
  assign {o_af_r, o_ae_r, o_ad_r, o_ac_r, o_ab_r, o_aa_r, o_a9_r, o_a8_r,
          o_a7_r, o_a6_r, o_a5_r, o_a4_r, o_a3_r, o_a2_r, o_a1_r, o_a0_r} = rdy;
`ifdef CORY_PACK16_BYPASS_EN
  assign o_z_v = &(full | in_v);
`else
  assign o_z_v = &full;
`endif
  assign fire  = o_z_v & i_z_r;
  assign o_z_d = lane_d;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int WK  = int'(W[k]);
    localparam int OFS = lane_ofs(W, k);
    cory_pack_lane #(.W(WK)) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .i_v    (in_v[k]),
      .i_d    (in_d[OFS +: WK]),
      .o_r    (rdy[k]),
      .i_fire (fire),
      .o_full (full[k]),
      .o_d    (lane_d[OFS +: WK])
    );
  end
`ifdef CORY_MON
  always_ff @(posedge clk) if (reset_n && fire) $display("cory_pack16 beat %h", o_z_d);
`endif
endmodule

// File: tb/tb_cory_pack16.sv
// tb_cory_pack16: queue-based model of the 16-lane joiner plus directed scenarios
module tb_cory_pack16;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic z_r = 1'b1;
  logic [15:0] v = '1;
  logic [15:0] r;
  logic [15:0][7:0] d;
  logic z_v;
  logic [127:0] z_d;
  int total = 0;
  int bad = 0;
  int beats = 0;
  logic [127:0] got[$];
  logic [7:0] q[16][$];

  always #5 clk = ~clk;

  cory_pack16 dut (
    .clk(clk), .reset_n(reset_n),
    .i_a0_v(v[0]),  .i_a0_d(d[0]),  .o_a0_r(r[0]),
    .i_a1_v(v[1]),  .i_a1_d(d[1]),  .o_a1_r(r[1]),
    .i_a2_v(v[2]),  .i_a2_d(d[2]),  .o_a2_r(r[2]),
    .i_a3_v(v[3]),  .i_a3_d(d[3]),  .o_a3_r(r[3]),
    .i_a4_v(v[4]),  .i_a4_d(d[4]),  .o_a4_r(r[4]),
    .i_a5_v(v[5]),  .i_a5_d(d[5]),  .o_a5_r(r[5]),
    .i_a6_v(v[6]),  .i_a6_d(d[6]),  .o_a6_r(r[6]),
    .i_a7_v(v[7]),  .i_a7_d(d[7]),  .o_a7_r(r[7]),
    .i_a8_v(v[8]),  .i_a8_d(d[8]),  .o_a8_r(r[8]),
    .i_a9_v(v[9]),  .i_a9_d(d[9]),  .o_a9_r(r[9]),
    .i_aa_v(v[10]), .i_aa_d(d[10]), .o_aa_r(r[10]),
    .i_ab_v(v[11]), .i_ab_d(d[11]), .o_ab_r(r[11]),
    .i_ac_v(v[12]), .i_ac_d(d[12]), .o_ac_r(r[12]),
    .i_ad_v(v[13]), .i_ad_d(d[13]), .o_ad_r(r[13]),
    .i_ae_v(v[14]), .i_ae_d(d[14]), .o_ae_r(r[14]),
    .i_af_v(v[15]), .i_af_d(d[15]), .o_af_r(r[15]),
    .o_z_v(z_v), .o_z_d(z_d), .i_z_r(z_r)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic all_held();
    for (int k = 0; k < 16; k++) if (q[k].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [127:0] head();
    logic [127:0] h = '0;
    for (int k = 0; k < 16; k++) h[k*8 +: 8] = q[k][0];
    return h;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [7:0] x);
    for (int k = 0; k < 16; k++) d[k] = x;
  endtask

  // model: each lane holds at most one value; a beat leaves when every lane holds one
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 16; k++) q[k].delete();
    end else begin
      logic f;
      f = all_held() && z_r;
      if (z_v && z_r) begin
        beats++;
        got.push_back(z_d);
      end
      for (int k = 0; k < 16; k++) begin
        logic rk;
        rk = (q[k].size() == 0) || f;
        if (f) void'(q[k].pop_front());
        if (v[k] && rk) q[k].push_back(d[k]);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 16; k++) q[k].delete();
      chk("reset_zv", 128'(z_v), '0);
      chk("reset_zd", z_d, '0);
    end else begin
      logic ev;
      logic [15:0] er;
      ev = all_held();
      chk("model_zv", 128'(z_v), 128'(ev));
      if (ev) chk("model_zd", z_d, head());
      for (int k = 0; k < 16; k++) er[k] = (q[k].size() == 0) || (ev && z_r);
      chk("model_ready", 128'(r), 128'(er));
    end
  end

  initial begin
    int b;
    for (int k = 0; k < 16; k++) d[k] = 8'(8'hA0 + k);
    #1 reset_n = 1'b0;
    step(2);
    chk("lit_reset_zv", 128'(z_v), '0);
    chk("lit_reset_zd", z_d, '0);
    reset_n = 1'b1;
    #1;
    chk("lit_ready_after_reset", 128'(r), 128'(16'hFFFF));
    step;
    chk("lit_zv_after_reset", 128'(z_v), 128'(1'b1));
    chk("lit_zd_after_reset", z_d, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    v = '0;
    step;
    chk("lit_first_fire", 128'(beats), 128'(1));
    chk("lit_zv_after_fire", 128'(z_v), '0);

    b = beats;
    for (int k = 0; k < 16; k++) begin
      v = 16'(1) << k;
      d[k] = 8'(8'h10 + k);
      step;
      if (k == 7) chk("lit_early_lane_stall", 128'(r[0]), '0);
      if (k == 14) chk("lit_no_beat_before_last", 128'(z_v), '0);
    end
    v = '0;
    chk("lit_stagger_zv", 128'(z_v), 128'(1'b1));
    chk("lit_stagger_zd", z_d, 128'h1F1E1D1C1B1A19181716151413121110);
    chk("lit_stagger_ready_on_fire", 128'(r), 128'(16'hFFFF));
    step;
    chk("lit_stagger_one_beat", 128'(beats), 128'(b + 1));

    b = beats;
    z_r = 1'b0;
    v = '1;
    for (int k = 0; k < 16; k++) d[k] = 8'(8'h50 + k);
    step;
    v = '0;
    for (int i = 0; i < 5; i++) begin
      chk("lit_stall_zv", 128'(z_v), 128'(1'b1));
      chk("lit_stall_zd", z_d, 128'h5F5E5D5C5B5A59585756555453525150);
      chk("lit_stall_ready", 128'(r), '0);
      step;
    end
    chk("lit_stall_no_beat", 128'(beats), 128'(b));
    z_r = 1'b1;
    step;
    chk("lit_release_zv", 128'(z_v), '0);
    step(2);
    chk("lit_release_one_beat", 128'(beats), 128'(b + 1));

    b = beats;
    got.delete();
    v = '1;
    for (int n = 1; n <= 20; n++) begin
      set_all(8'(n));
      step;
    end
    v = '0;
    step(2);
    chk("lit_stream_count", 128'(beats), 128'(b + 20));
    for (int n = 1; n <= 20 && n <= got.size(); n++) begin
      logic [7:0] nb;
      nb = 8'(n);
      chk("lit_stream_beat", got[n-1], {16{nb}});
    end

    b = beats;
    v = 16'h00FF;
    set_all(8'h77);
    step;
    v = '0;
    step;
    reset_n = 1'b0;
    step;
    reset_n = 1'b1;
    step(3);
    chk("lit_midreset_no_beat", 128'(beats), 128'(b));
    chk("lit_midreset_zv", 128'(z_v), '0);
    v = '1;
    set_all(8'h33);
    step;
    v = '0;
    chk("lit_after_midreset_zv", 128'(z_v), 128'(1'b1));
    chk("lit_after_midreset_zd", z_d, {16{8'h33}});
    step;
    chk("lit_after_midreset_one_beat", 128'(beats), 128'(b + 1));
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
